accumulator_nbit_scan: RTL

Parametrised successor to the 4-bit board accumulator. It holds an N-bit running total and adds or subtracts switch input `X` on each debounced press of the load button. It reports unsigned carry/borrow and signed overflow flags. The total is shown as hex on up to eight time-multiplexed seven-segment digits. It sits at the top of the lab design, between the board switches/buttons and the SSEG/AN pins, and replaces the single-digit, undebounced, always-on-digit-0 arrangement.

---
 rtl/accumulator_nbit_scan.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/accumulator_nbit_scan.sv
// accumulator_nbit_scan: N-bit add/subtract accumulator driven by debounced
// load/clear buttons, with carry/borrow and signed overflow flags and a
// time-multiplexed hex display of the running total.

// Button conditioning path: two-flop synchroniser, debounce counter and
// rising-edge detector producing one pulse per accepted press.
module button_conditioner #(
    parameter int DEBOUNCE = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button,
    output logic press
);

    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    logic [1:0]    sync;
    logic          deb;
    logic          deb_q;
    logic [CW-1:0] cnt;

    // Bring the raw asynchronous button into the clock domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[0], button};
        end
    end

    // Accept a new level only after DEBOUNCE consecutive differing samples;
    // any sample matching the accepted level restarts the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            deb <= 1'b0;
        end else if (sync[1] == deb) begin
            cnt <= '0;
        end else if (cnt == CW'(DEBOUNCE - 1)) begin
            deb <= sync[1];
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Delayed copy of the accepted level for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_q <= 1'b0;
        end else begin
            deb_q <= deb;
        end
    end

    assign press = deb & ~deb_q;

endmodule

module accumulator_nbit_scan #(
    parameter int N            = 16,
    parameter int DIGITS       = N / 4,
    parameter int DEBOUNCE     = 1_000_000,
    parameter int REFRESH_BITS = 17
) (
    input  logic         CLK100MHZ,
    input  logic         resetn,
    input  logic [N-1:0] X,
    input  logic         op_sel,
    input  logic         loadButton,
    input  logic         clearButton,
    output logic [N-1:0] ACC,
    output logic         carry,
    output logic         ovf,
    output logic [6:0]   SSEG,
    output logic [7:0]   AN
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic                    load_pulse;
    logic                    clear_pulse;
    logic [N:0]              ext_result;
    logic [N-1:0]            result;
    logic                    carry_next;
    logic                    ovf_next;
    logic [REFRESH_BITS-1:0] refresh_cnt;
    logic [IDX_W-1:0]        digit_idx;
    logic [IDX_W-1:0]        digit_next;
    logic [3:0]              nibble;
    logic [6:0]              glyph;
    logic [7:0]              an_next;

    button_conditioner #(.DEBOUNCE(DEBOUNCE)) u_load_btn (
        .clk    (CLK100MHZ),
        .rst_n  (resetn),
        .button (loadButton),
        .press  (load_pulse)
    );

    button_conditioner #(.DEBOUNCE(DEBOUNCE)) u_clear_btn (
        .clk    (CLK100MHZ),
        .rst_n  (resetn),
        .button (clearButton),
        .press  (clear_pulse)
    );

    // Add or subtract with one extra bit so the top bit is carry-out or borrow.
    always_comb begin
        ext_result = '0;
        ovf_next   = 1'b0;
        if (op_sel) begin
            ext_result = {1'b0, ACC} - {1'b0, X};
        end else begin
            ext_result = {1'b0, ACC} + {1'b0, X};
        end
        result     = ext_result[N-1:0];
        carry_next = ext_result[N];
        if (op_sel) begin
            ovf_next = (ACC[N-1] != X[N-1]) && (result[N-1] != ACC[N-1]);
        end else begin
            ovf_next = (ACC[N-1] == X[N-1]) && (result[N-1] != ACC[N-1]);
        end
    end

    // Accumulator and flags; clear takes priority over a same-cycle load.
    always_ff @(posedge CLK100MHZ or negedge resetn) begin
        if (!resetn) begin
            ACC   <= '0;
            carry <= 1'b0;
            ovf   <= 1'b0;
        end else if (clear_pulse) begin
            ACC   <= '0;
            carry <= 1'b0;
            ovf   <= 1'b0;
        end else if (load_pulse) begin
            ACC   <= result;
            carry <= carry_next;
            ovf   <= ovf_next;
        end
    end

    // Pick the digit for the next cycle: advance on refresh wrap, then fetch its nibble and anode.
    always_comb begin
        digit_next = digit_idx;
        if (&refresh_cnt) begin
            if (digit_idx == IDX_W'(DIGITS - 1)) begin
                digit_next = '0;
            end else begin
                digit_next = digit_idx + 1'b1;
            end
        end
        nibble  = 4'(ACC >> {digit_next, 2'b00});
        an_next = ~(8'b0000_0001 << digit_next);
    end

    // Active-low hex glyphs, bit order {g,f,e,d,c,b,a}.
    always_comb begin
        glyph = 7'b1000000;
        case (nibble)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            4'hF: glyph = 7'b0001110;
            default: glyph = 7'b1000000;
        endcase
    end

    // Refresh counter, digit index and registered display outputs move together.
    always_ff @(posedge CLK100MHZ or negedge resetn) begin
        if (!resetn) begin
            refresh_cnt <= '0;
            digit_idx   <= '0;
            AN          <= 8'b1111_1110;
            SSEG        <= 7'b1000000;
        end else begin
            refresh_cnt <= refresh_cnt + 1'b1;
            digit_idx   <= digit_next;
            AN          <= an_next;
            SSEG        <= glyph;
        end
    end

endmodule
